serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around the existing full_adder cell: one full_adder plus a carry flip-flop.

---
 rtl/hack_alu_pkg.sv | 20 ++
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// +----------------------------------------------------------------------+
// | hack_alu_pkg                                                         |
// | Shared state encoding and default width for the Hack ALU adders.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package hack_alu_pkg;

  localparam int unsigned c_default_width = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// +----------------------------------------------------------------------+
// | full_adder                                                           |
// | Single-bit combinational full adder cell.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// +----------------------------------------------------------------------+
// | serial_adder                                                         |
// | Bit-serial WIDTH-bit adder: one full_adder plus a carry flip-flop,   |
// | LSB-first, valid/ready on both sides. SERIAL_ADDER_SUB_EN adds the   |
// | `sub` port for a - b.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_adder
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and inject a forced carry of 1.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  assign w_sum_next = (r_sum_sh >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a_sh     <= a;
            r_b_sh     <= w_b_load;
            r_carry    <= w_c_load;
            r_sum_sh   <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + c_cnt_one;
          if (r_cnt == c_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_fa_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// +----------------------------------------------------------------------+
// | tb_serial_adder                                                      |
// | Directed self-checking bench for serial_adder (WIDTH=16 and 1).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub;
`endif

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0]  a1, b1, sum1;
  logic        cin1, cout1;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    chk("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // {a, b, cin, expected sum, expected cout}
  logic [49:0] vecs [8] = '{
    {16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0},
    {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
    {16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0},
    {16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1},
    {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1},
    {16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0},
    {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
    {16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0}
  };

  // WIDTH=1 truth table indexed by {a,b,cin}: {cout,sum}
  logic [1:0] exp1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    int lat;
    logic [49:0] v;
    logic [2:0]  idx;

    rst_n = 1'b0; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0; cin1 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 0; sub1 = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      send(v[49:34], v[33:18], v[17]);
      wait_valid(lat);
      chk($sformatf("latency_v%0d", i), lat, 16);
      chk($sformatf("sum_v%0d", i), sum, v[16:1]);
      chk($sformatf("cout_v%0d", i), cout, v[0]);
      release_result();
      chk($sformatf("idle_after_v%0d", i), {in_ready, out_valid}, 2'b10);
    end

    // Result must hold under backpressure while new operands are offered.
    send(16'h0F0F, 16'h00F1, 1'b1);
    wait_valid(lat);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", sum, 16'h1001);
      chk("hold_cout", cout, 0);
      chk("hold_flags", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    release_result();
    chk("hold_released", {in_ready, out_valid}, 2'b10);

    // Reset mid-BUSY drops the pending result and clears the held sum.
    send(16'h0001, 16'h0002, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(lat);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_sum", sum, 16'h5555);
    chk("post_rst_cout", cout, 0);
    release_result();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    send(16'h0005, 16'h0007, 1'b0);
    wait_valid(lat);
    chk("sub_5m7_sum", sum, 16'hFFFE);
    chk("sub_5m7_cout", cout, 0);
    release_result();
    send(16'h0007, 16'h0005, 1'b0);
    wait_valid(lat);
    chk("sub_7m5_sum", sum, 16'h0002);
    chk("sub_7m5_cout", cout, 1);
    release_result();
    sub = 1'b0;
`endif

    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      chk("w1_in_ready", in_ready1, 1);
      a1 = idx[2]; b1 = idx[1]; cin1 = idx[0]; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("w1_latency_%0d", i), lat, 1);
      chk($sformatf("w1_result_%0d", i), {cout1, sum1}, exp1[i]);
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
